// File: rtl/dco_cal_ctrl.sv
// Successive-approximation DCO tuner: 8 trials of SETTLE+WINDOW+1 cycles each, then holds the
// largest code whose windowed edge count is <= target. No backpressure; start ignored while busy.
module dco_cal_ctrl #(
   parameter int WINDOW = 256,
   parameter int SETTLE = 16,
   parameter int CNT_W  = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] target,
   input  logic             dco_in,
   output logic [7:0]       dco_code,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] meas_cnt
);
   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [2:0]         r_bit;
   logic [7:0]         r_code;
   logic               r_busy;
   logic               r_done;
   logic [CNT_W-1:0]   r_target;
   logic [CNT_W-1:0]   r_edge_cnt;
   logic [CNT_W-1:0]   r_meas;
   logic [TMR_W-1:0]   r_timer;
   logic               r_s1;
   logic               r_s2;
   logic               r_s3;

   logic               w_edge;
   logic               w_keep;
   logic               w_cnt_sat;
   logic [7:0]         w_cur_mask;
   logic [7:0]         w_kept_code;
   logic [7:0]         w_next_code;

   // dco_in is asynchronous: two flops to resolve metastability, a third to find the rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= dco_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge      = r_s2 & ~r_s3;
   assign w_cnt_sat   = &r_edge_cnt;
   assign w_keep      = (r_edge_cnt <= r_target);
   assign w_cur_mask  = 8'h01 << r_bit;
   assign w_kept_code = w_keep ? r_code : (r_code & ~w_cur_mask);
   // On the last bit the shifted mask is zero, so the kept code is final
   assign w_next_code = w_kept_code | (w_cur_mask >> 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_bit      <= 3'd0;
         r_code     <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_target   <= '0;
         r_edge_cnt <= '0;
         r_meas     <= '0;
         r_timer    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_target <= target;
                  r_bit    <= 3'd7;
                  r_code   <= 8'h80;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_timer  <= '0;
                  r_state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_timer == TMR_W'(SETTLE - 1)) begin
                  r_timer    <= '0;
                  r_edge_cnt <= '0;
                  r_state    <= S_MEASURE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_MEASURE: begin
               if (w_edge && !w_cnt_sat) begin
                  r_edge_cnt <= r_edge_cnt + 1'b1;
               end
               if (r_timer == TMR_W'(WINDOW - 1)) begin
                  r_timer <= '0;
                  r_state <= S_COMPARE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_COMPARE: begin
               r_meas <= r_edge_cnt;
               r_code <= w_next_code;
               if (r_bit != 3'd0) begin
                  r_bit   <= r_bit - 3'd1;
                  r_state <= S_SETTLE;
               end else begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dco_code = r_code;
   assign busy     = r_busy;
   assign done     = r_done;
   assign meas_cnt = r_meas;

endmodule

// File: tb/tb_dco_cal_ctrl.sv
// Bench for dco_cal_ctrl: a DCO model emitting code>>1 pulses per measurement window,
// compared against a brute-force search for the largest code meeting the target.
module tb_dco_cal_ctrl;
   localparam int SETTLE = 16;
   localparam int WINDOW = 256;
   localparam int TRIAL  = SETTLE + WINDOW + 1;
   localparam int TOTAL  = 8 * TRIAL;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] target = 12'd0;
   logic        dco_in = 1'b0;
   logic [7:0]  dco_code;
   logic        busy;
   logic        done;
   logic [11:0] meas_cnt;

   logic        start_s = 1'b0;
   logic [3:0]  target_s = 4'd0;
   logic        dco_s = 1'b0;
   logic [7:0]  code_s;
   logic        busy_s;
   logic        done_s;
   logic [3:0]  meas_s;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int run_start = 0;
   bit dco_en = 1'b0;
   int m_off, m_p, m_n;

   dco_cal_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(12)) u_dut (
      .clk(clk), .reset(reset), .start(start), .target(target), .dco_in(dco_in),
      .dco_code(dco_code), .busy(busy), .done(done), .meas_cnt(meas_cnt));

   dco_cal_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .start(start_s), .target(target_s), .dco_in(dco_s),
      .dco_code(code_s), .busy(busy_s), .done(done_s), .meas_cnt(meas_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DCO model: code>>1 pulses, 2 cycles apart, starting when the measurement window opens
   always @(negedge clk) begin
      dco_in = 1'b0;
      if (dco_en) begin
         m_off = cyc - run_start;
         m_p   = m_off % TRIAL;
         m_n   = int'(dco_code >> 1);
         if (m_off < TOTAL && m_p >= SETTLE && ((m_p - SETTLE) % 2 == 0) && ((m_p - SETTLE) / 2 < m_n))
            dco_in = 1'b1;
      end
      dco_s = ~dco_s;
   end

   function automatic int best_code(input int tgt);
      int best = 0;
      for (int c = 0; c < 256; c++)
         if ((c >> 1) <= tgt) best = c;
      return best;
   endfunction

   function automatic logic [7:0] trial_code(input int tgt, input int t);
      logic [7:0] code = 8'h00;
      logic [7:0] tr = 8'h00;
      for (int i = 0; i <= t; i++) begin
         tr = code | 8'(1 << (7 - i));
         if (int'(tr >> 1) <= tgt) code = tr;
      end
      return tr;
   endfunction

   task automatic start_cal(input logic [11:0] tgt);
      @(negedge clk);
      target = tgt;
      start  = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      target    = 12'($urandom);
      run_start = cyc;
      dco_en    = 1'b1;
   endtask

   task automatic wait_done(input int budget, output int lat, output bit timed_out);
      lat = 0;
      while (lat < budget && done !== 1'b1) begin
         @(negedge clk);
         lat++;
      end
      timed_out = (done !== 1'b1);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (dco_code !== 8'h00) begin errors++; $display("FAIL reset_code got=%h exp=00", dco_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (meas_cnt !== 12'd0) begin errors++; $display("FAIL reset_meas got=%0d exp=0", meas_cnt); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] exp_code;
      start_cal(12'd50);
      checks++; if (busy !== 1'b1 || dco_code !== 8'h80) begin
         errors++; $display("FAIL basic_first busy=%b code=%h exp busy=1 code=80", busy, dco_code); end
      for (int off = 1; off < TOTAL; off++) begin
         @(negedge clk);
         if (off % TRIAL == 0 || off % TRIAL == TRIAL - 1) begin
            exp_code = trial_code(50, off / TRIAL);
            checks++; if (dco_code !== exp_code) begin
               errors++; $display("FAIL basic_trial off=%0d got=%h exp=%h", off, dco_code, exp_code); end
         end
         checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL basic_busy off=%0d busy=%b done=%b exp busy=1 done=0", off, busy, done); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_done busy=%b done=%b exp busy=0 done=1", busy, done); end
      checks++; if (dco_code !== 8'h65) begin errors++; $display("FAIL basic_code got=%h exp=65", dco_code); end
      checks++; if (meas_cnt !== 12'd50) begin errors++; $display("FAIL basic_meas got=%0d exp=50", meas_cnt); end
      repeat (40) @(negedge clk);
      checks++; if (done !== 1'b1 || dco_code !== 8'h65) begin
         errors++; $display("FAIL basic_hold done=%b code=%h exp done=1 code=65", done, dco_code); end
   endtask

   task automatic test_targets(input int tgt, input string name);
      int lat;
      bit to;
      int exp_code;
      exp_code = best_code(tgt);
      start_cal(12'(tgt));
      wait_done(TOTAL + 50, lat, to);
      checks++; if (to || lat != TOTAL) begin
         errors++; $display("FAIL %s_latency got=%0d timeout=%0b exp=%0d", name, lat, to, TOTAL); end
      checks++; if (dco_code !== 8'(exp_code)) begin
         errors++; $display("FAIL %s_code tgt=%0d got=%h exp=%h", name, tgt, dco_code, 8'(exp_code)); end
      checks++; if (meas_cnt !== 12'((exp_code | 1) >> 1)) begin
         errors++; $display("FAIL %s_meas tgt=%0d got=%0d exp=%0d", name, tgt, meas_cnt, (exp_code | 1) >> 1); end
   endtask

   task automatic test_start_ignored;
      int lat;
      bit to;
      start_cal(12'd50);
      repeat (500) @(negedge clk);
      target = 12'd5;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(TOTAL + 50, lat, to);
      checks++; if (to || lat + 501 != TOTAL) begin
         errors++; $display("FAIL ignored_latency got=%0d timeout=%0b exp=%0d", lat + 501, to, TOTAL); end
      checks++; if (dco_code !== 8'h65) begin errors++; $display("FAIL ignored_code got=%h exp=65", dco_code); end
      checks++; if (meas_cnt !== 12'd50) begin errors++; $display("FAIL ignored_meas got=%0d exp=50", meas_cnt); end
   endtask

   task automatic test_reset_mid;
      start_cal(12'd50);
      repeat (3 * TRIAL + 100) @(negedge clk);
      checks++; if (busy !== 1'b1 || meas_cnt === 12'd0) begin
         errors++; $display("FAIL midrun_state busy=%b meas=%0d exp busy=1 meas!=0", busy, meas_cnt); end
      #2 reset = 1'b1;
      dco_en = 1'b0;
      #1;
      checks++; if (dco_code !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || meas_cnt !== 12'd0) begin
         errors++; $display("FAIL async_reset code=%h busy=%b done=%b meas=%0d exp all 0", dco_code, busy, done, meas_cnt); end
      @(negedge clk);
      reset = 1'b0;
      test_targets(20, "after_reset");
      checks++; if (dco_code !== 8'h29) begin errors++; $display("FAIL after_reset_fixed got=%h exp=29", dco_code); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 5; i++) test_targets(int'($urandom_range(0, 300)), "random");
   endtask

   task automatic test_saturation;
      int lat = 0;
      @(negedge clk);
      target_s = 4'd14;
      start_s  = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      while (lat < TOTAL + 50 && done_s !== 1'b1) begin
         @(negedge clk);
         lat++;
         if (lat == TRIAL) begin
            checks++; if (meas_s !== 4'd15) begin errors++; $display("FAIL sat_first_meas got=%0d exp=15", meas_s); end
         end
      end
      checks++; if (lat != TOTAL) begin errors++; $display("FAIL sat_latency got=%0d exp=%0d", lat, TOTAL); end
      checks++; if (code_s !== 8'h00) begin errors++; $display("FAIL sat_code got=%h exp=00", code_s); end
      checks++; if (meas_s !== 4'd15) begin errors++; $display("FAIL sat_meas got=%0d exp=15", meas_s); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_targets(0, "lower");
      test_targets(127, "upper");
      test_start_ignored();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
